circuito_exp6: RTL and testbench
================================

// Module: circuito_exp6
// PURPOSE
//  Sequence-memory game (Genius/Simon) top: shows a growing LED sequence from ROM,
//  then checks the player's button presses against it, round by round.
//  Win after the last round; lose on a wrong press or on a play timeout.
//  Top-level block with 7-segment debug outputs for the FPGA board (1 kHz clock).
// PARAMETERS
//  TIMEOUT_CYC  5000  idle cycles in a play wait before timeout
//  SHOW_ON      500   cycles each sequence LED is lit
//  SHOW_OFF     250   dark cycles between shown LEDs
// PORTS
//  clock           in   1  system clock, single clock domain
//  reset           in   1  synchronous, active-high
//  jogar           in   1  start/restart (level, sampled in idle/end states)
//  botoes          in   4  player buttons, one-hot when pressed
//  dificuldade     in   1  0: 8 rounds, 1: 16 rounds (sampled on start)
//  memoria         in   1  ROM select: 0 = ROM A, 1 = ROM B (sampled on start)
//  ganhou/perdeu   out  1  win / lose flags, held in end state
//  pronto          out  1  game finished (any end state)
//  timeout         out  1  lose was caused by timeout
//  leds            out  4  sequence display / echo of registered play
//  db_igual        out  1  current play == ROM word
//  db_contagem     out  7  7-seg of play address
//  db_memoria      out  7  7-seg of ROM word
//  db_estado       out  7  7-seg of FSM state code
//  db_jogadafeita  out  7  7-seg of registered play
//  db_seqCont      out  7  7-seg of round (sequence length-1)
//  db_clock/db_iniciar/db_tem_jogada  out 1  copies of clock, jogar, any-button
//  db_mostra_leds  out  1  high while sequence is being shown
// BEHAVIOUR
//  - Reset: FSM->INICIAL(0); all flags, leds=0; counters, play reg cleared.
//  - 7-seg: active-low, bit6..0=g..a, hex 0-F.
//  - ROM A (addr 0..15): 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4; ROM B: 8,4,2,1 repeated.
//  - States/codes: INICIAL 0, PREPARA 1, MOSTRA 2, APAGA 3, ESPERA 4, REGISTRA 5,
//    COMPARA 6, PROX_JOG 7, PROX_RODADA 8, GANHOU A, PERDEU E, TIMEOUT F.
//  - INICIAL/GANHOU/PERDEU/TIMEOUT: jogar=1 -> PREPARA (clears round, addr, flags).
//  - PREPARA -> MOSTRA; MOSTRA: leds=ROM[addr] for SHOW_ON cycles -> APAGA
//    (leds=0, SHOW_OFF cycles); addr<round: addr++ -> MOSTRA, else addr=0 -> ESPERA.
//    db_mostra_leds=1 in MOSTRA/APAGA only.
//  - Button: rising edge of |botoes (synchronised edge detector) = one play;
//    held buttons count once; presses outside ESPERA ignored.
//  - ESPERA: play -> REGISTRA (latch botoes) -> COMPARA, 1 cycle each.
//    COMPARA: mismatch -> PERDEU; match & addr<round -> PROX_JOG (addr++) -> ESPERA;
//    match & addr==round -> PROX_RODADA: last round -> GANHOU, else round++, addr=0 -> MOSTRA.
//  - Timeout counter clears on ESPERA entry and each play; reaching TIMEOUT_CYC in
//    ESPERA -> TIMEOUT: perdeu=1, timeout=1.
//  - End states hold outputs; pronto=1; later presses ignored. reset wins over all.
// CONFIGURATION
//  CIRCUITO_EXP6_TIMEOUT_EN defined: timeout as above.
//  Undefined: no timeout counter, ESPERA waits forever, timeout tied 0.
// TESTING
//  reset, jogar 5 cycles -> PREPARA then MOSTRA; leds 1,(gap) ; db_mostra_leds pulses.
//  rounds 0-2 played correctly (1 / 1,2 / 1,2,4), 10-cycle presses -> round advances, ganhou=0.
//  round 3 idle 5500 cycles (TIMEOUT_EN) -> timeout=1, perdeu=1, pronto=1 at 5000; later presses ignored.
//  dificuldade=1, all 16 rounds correct -> ganhou=1, pronto=1; dificuldade=0 -> win after 8.
//  wrong press (2 instead of 1) in round 0 -> perdeu=1, timeout=0.
//  reset mid-MOSTRA -> INICIAL next edge, leds=0, db_estado=7-seg "0".

Source files
------------

// File: rtl/circuito_exp6.sv
// Genius/Simon sequence-memory game: shows a growing LED sequence from ROM,
// then checks the player's presses round by round; 7-seg debug outputs.
// Ports: clock, reset (sync, active-high), jogar, botoes[3:0], dificuldade,
//   memoria -> ganhou, perdeu, pronto, timeout, leds[3:0], db_* debug.
// Build option: CIRCUITO_EXP6_TIMEOUT_EN enables the play-wait timeout.
module circuito_exp6 #(
  parameter int TIMEOUT_CYC = 5000,
  parameter int SHOW_ON     = 500,
  parameter int SHOW_OFF    = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  input  logic       dificuldade,
  input  logic       memoria,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_seqCont,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_tem_jogada,
  output logic       db_mostra_leds
);

  localparam logic [3:0] S_INICIAL  = 4'h0;
  localparam logic [3:0] S_PREPARA  = 4'h1;
  localparam logic [3:0] S_MOSTRA   = 4'h2;
  localparam logic [3:0] S_APAGA    = 4'h3;
  localparam logic [3:0] S_ESPERA   = 4'h4;
  localparam logic [3:0] S_REGISTRA = 4'h5;
  localparam logic [3:0] S_COMPARA  = 4'h6;
  localparam logic [3:0] S_PROX_JOG = 4'h7;
  localparam logic [3:0] S_PROX_ROD = 4'h8;
  localparam logic [3:0] S_GANHOU   = 4'hA;
  localparam logic [3:0] S_PERDEU   = 4'hE;
  localparam logic [3:0] S_TIMEOUT  = 4'hF;

  localparam logic [15:0] ON_LAST  = 16'(SHOW_ON - 1);
  localparam logic [15:0] OFF_LAST = 16'(SHOW_OFF - 1);

  function automatic logic [3:0] rom_word(
    input logic sel, input logic [3:0] a);
    logic [3:0] w;
    w = 4'h0;
    if (sel) begin
      w = 4'b1000 >> a[1:0];
    end else begin
      case (a)
        4'd0, 4'd6, 4'd7, 4'd14: w = 4'h1;
        4'd1, 4'd5, 4'd8, 4'd9:  w = 4'h2;
        4'd2, 4'd4, 4'd10, 4'd11,
        4'd15:                   w = 4'h4;
        default:                 w = 4'h8;
      endcase
    end
    return w;
  endfunction

  // Active-low segments, bit 6..0 = g..a.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06;
      4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D;
      4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F;
      4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E;
      4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return ~s;
  endfunction

  logic [3:0]  state_q, state_d;
  logic [3:0]  round_q, round_d;
  logic [3:0]  addr_q, addr_d;
  logic [3:0]  play_q, play_d;
  logic [15:0] tmr_q, tmr_d;
  logic        dif_q, dif_d;
  logic        mem_q, mem_d;
  logic        s1_q, s2_q, prev_q;
  logic        press;
  logic [3:0]  rom_q;
  logic [3:0]  last_round;

`ifdef CIRCUITO_EXP6_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] to_q, to_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

  // Two-flop synchroniser then edge detect: a held button is one play.
  assign press      = s2_q & ~prev_q;
  assign rom_q      = rom_word(mem_q, addr_q);
  assign last_round = dif_q ? 4'd15 : 4'd7;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    addr_d  = addr_q;
    play_d  = play_q;
    tmr_d   = tmr_q;
    dif_d   = dif_q;
    mem_d   = mem_q;
`ifdef CIRCUITO_EXP6_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      S_INICIAL, S_GANHOU, S_PERDEU, S_TIMEOUT: begin
        if (jogar) begin
          state_d = S_PREPARA;
          round_d = 4'd0;
          addr_d  = 4'd0;
          play_d  = 4'd0;
          dif_d   = dificuldade;
          mem_d   = memoria;
        end
      end
      S_PREPARA: begin
        tmr_d   = 16'd0;
        state_d = S_MOSTRA;
      end
      S_MOSTRA: begin
        if (tmr_q == ON_LAST) begin
          tmr_d   = 16'd0;
          state_d = S_APAGA;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_APAGA: begin
        if (tmr_q == OFF_LAST) begin
          tmr_d = 16'd0;
          if (addr_q < round_q) begin
            addr_d  = addr_q + 4'd1;
            state_d = S_MOSTRA;
          end else begin
            addr_d  = 4'd0;
            state_d = S_ESPERA;
`ifdef CIRCUITO_EXP6_TIMEOUT_EN
            to_d    = 16'd0;
`endif
          end
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_ESPERA: begin
        if (press) begin
          state_d = S_REGISTRA;
`ifdef CIRCUITO_EXP6_TIMEOUT_EN
          to_d    = 16'd0;
        end else if (to_q == TO_LAST) begin
          state_d = S_TIMEOUT;
        end else begin
          to_d = to_q + 16'd1;
`endif
        end
      end
      S_REGISTRA: begin
        play_d  = botoes;
        state_d = S_COMPARA;
      end
      S_COMPARA: begin
        if (play_q != rom_q)
          state_d = S_PERDEU;
        else if (addr_q < round_q)
          state_d = S_PROX_JOG;
        else
          state_d = S_PROX_ROD;
      end
      S_PROX_JOG: begin
        addr_d  = addr_q + 4'd1;
        state_d = S_ESPERA;
`ifdef CIRCUITO_EXP6_TIMEOUT_EN
        to_d    = 16'd0;
`endif
      end
      S_PROX_ROD: begin
        if (round_q == last_round) begin
          state_d = S_GANHOU;
        end else begin
          round_d = round_q + 4'd1;
          addr_d  = 4'd0;
          tmr_d   = 16'd0;
          state_d = S_MOSTRA;
        end
      end
      default: state_d = S_INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INICIAL;
      round_q <= 4'd0;
      addr_q  <= 4'd0;
      play_q  <= 4'd0;
      tmr_q   <= 16'd0;
      dif_q   <= 1'b0;
      mem_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
`ifdef CIRCUITO_EXP6_TIMEOUT_EN
      to_q    <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      addr_q  <= addr_d;
      play_q  <= play_d;
      tmr_q   <= tmr_d;
      dif_q   <= dif_d;
      mem_q   <= mem_d;
      s1_q    <= |botoes;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
`ifdef CIRCUITO_EXP6_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  // Flags are decoded from the end states, so they hold until restart.
  assign ganhou  = (state_q == S_GANHOU);
  assign perdeu  = (state_q == S_PERDEU) || (state_q == S_TIMEOUT);
  assign timeout = (state_q == S_TIMEOUT);
  assign pronto  = ganhou || perdeu;

  always_comb begin
    leds = 4'h0;
    if (state_q == S_MOSTRA)
      leds = rom_q;
    else if (state_q == S_COMPARA)
      leds = play_q;
  end

  assign db_mostra_leds = (state_q == S_MOSTRA) || (state_q == S_APAGA);
  assign db_igual       = (play_q == rom_q);
  assign db_contagem    = hex7(addr_q);
  assign db_memoria     = hex7(rom_q);
  assign db_estado      = hex7(state_q);
  assign db_jogadafeita = hex7(play_q);
  assign db_seqCont     = hex7(round_q);
  assign db_clock       = clock;
  assign db_iniciar     = jogar;
  assign db_tem_jogada  = |botoes;

endmodule

// File: tb/tb_circuito_exp6.sv
// Bench for circuito_exp6: scoreboard of shown LED words plus
// scenario tasks for start, rounds, timeout, win, loss and reset.
module tb_circuito_exp6;

  localparam int T_ON  = 20;
  localparam int T_OFF = 10;
  localparam int T_TO  = 400;

  logic       clock = 1'b0;
  logic       reset, jogar, dificuldade, memoria;
  logic [3:0] botoes;
  logic       ganhou, perdeu, pronto, timeout;
  logic [3:0] leds;
  logic       db_igual;
  logic [6:0] db_contagem, db_memoria, db_estado;
  logic [6:0] db_jogadafeita, db_seqCont;
  logic       db_clock, db_iniciar, db_tem_jogada, db_mostra_leds;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] prev_leds = 4'h0;

  circuito_exp6 #(
    .TIMEOUT_CYC(T_TO), .SHOW_ON(T_ON), .SHOW_OFF(T_OFF)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .dificuldade(dificuldade), .memoria(memoria),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
    .timeout(timeout), .leds(leds), .db_igual(db_igual),
    .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_estado(db_estado), .db_jogadafeita(db_jogadafeita),
    .db_seqCont(db_seqCont), .db_clock(db_clock),
    .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada),
    .db_mostra_leds(db_mostra_leds)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B;
      4'h3: s = 7'h4F; 4'h4: s = 7'h66; 4'h5: s = 7'h6D;
      4'h6: s = 7'h7D; 4'h7: s = 7'h07; 4'h8: s = 7'h7F;
      4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return ~s;
  endfunction

  function automatic logic [3:0] rom(input logic m, input int i);
    logic [3:0] ta [16];
    ta = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
    if (m) return 4'(8 >> (i % 4));
    return ta[i % 16];
  endfunction

  // Every clock advance goes through here; a new lit word on the
  // display is popped from the scoreboard and compared.
  task automatic step();
    logic [3:0] e;
    @(negedge clock);
    if (db_mostra_leds && leds != 4'h0 && prev_leds == 4'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL show_extra leds=%h expected none", leds);
      end else begin
        e = exp_q.pop_front();
        if (leds !== e) begin
          errors++;
          $display("FAIL show_word leds=%h expected %h", leds, e);
        end
      end
    end
    prev_leds = leds;
  endtask

  task automatic push_show(input logic m, input int r);
    for (int i = 0; i <= r; i++) exp_q.push_back(rom(m, i));
  endtask

  task automatic chk(input string nm, input logic [6:0] got,
                     input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected %h", nm, got, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (db_estado !== seg(s) && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("wait_state_%h", s), db_estado, seg(s));
  endtask

  task automatic press(input logic [3:0] b);
    botoes = b;
    step();
    chk("tem_jogada", 7'(db_tem_jogada), 7'(b != 4'h0));
    repeat (9) step();
    botoes = 4'h0;
    repeat (5) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    jogar = 1'b0;
    botoes = 4'h0;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    step();
  endtask

  task automatic start(input logic d, input logic m);
    dificuldade = d;
    memoria = m;
    jogar = 1'b1;
    push_show(m, 0);
    step();
    chk("start_prepara", db_estado, seg(4'h1));
    chk("start_iniciar", 7'(db_iniciar), 7'd1);
    chk("start_flags", 7'({ganhou, perdeu, pronto, timeout}), 7'd0);
    step();
    chk("start_mostra", db_estado, seg(4'h2));
    chk("start_mostra_leds", 7'(db_mostra_leds), 7'd1);
    repeat (3) step();
    jogar = 1'b0;
  endtask

  task automatic play_round(input logic m, input int r,
                            input bit last);
    for (int i = 0; i <= r; i++) begin
      wait_state(4'h4, (T_ON + T_OFF) * 17 + 60);
      if (i == 0) chk("show_drained", 7'(exp_q.size()), 7'd0);
      if (i == r && !last) push_show(m, r + 1);
      press(rom(m, i));
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_estado", db_estado, seg(4'h0));
    chk("rst_leds", 7'(leds), 7'd0);
    chk("rst_flags", 7'({ganhou, perdeu, pronto, timeout}), 7'd0);
    chk("rst_mostra", 7'(db_mostra_leds), 7'd0);
    chk("rst_seq", db_seqCont, seg(4'h0));
    chk("db_clock_low", 7'(db_clock), 7'd0);
  endtask

  task automatic test_rounds_timeout();
    do_reset();
    start(1'b0, 1'b0);
    for (int r = 0; r < 3; r++) play_round(1'b0, r, 1'b0);
    wait_state(4'h4, (T_ON + T_OFF) * 5 + 60);
    chk("r3_drained", 7'(exp_q.size()), 7'd0);
    chk("r3_round", db_seqCont, seg(4'h3));
    chk("r3_ganhou", 7'(ganhou), 7'd0);
    repeat (T_TO - 10) step();
    chk("to_early", db_estado, seg(4'h4));
    chk("to_early_flag", 7'(timeout), 7'd0);
    repeat (20) step();
`ifdef CIRCUITO_EXP6_TIMEOUT_EN
    chk("to_state", db_estado, seg(4'hF));
    chk("to_flags", 7'({perdeu, pronto, timeout, ganhou}), 7'b1110);
    press(4'h1);
    chk("to_hold", db_estado, seg(4'hF));
    chk("to_hold_flags", 7'({perdeu, pronto, timeout}), 7'b111);
`else
    chk("noto_state", db_estado, seg(4'h4));
    chk("noto_flags", 7'({perdeu, pronto, timeout}), 7'd0);
`endif
  endtask

  task automatic test_win16();
    do_reset();
    start(1'b1, 1'b1);
    for (int r = 0; r < 16; r++) play_round(1'b1, r, r == 15);
    wait_state(4'hA, 40);
    chk("w16_flags", 7'({ganhou, pronto, perdeu, timeout}), 7'b1100);
    chk("w16_round", db_seqCont, seg(4'hF));
  endtask

  task automatic test_win8_restart();
    start(1'b0, 1'b0);
    for (int r = 0; r < 8; r++) play_round(1'b0, r, r == 7);
    wait_state(4'hA, 40);
    chk("w8_flags", 7'({ganhou, pronto, perdeu}), 7'b110);
    chk("w8_round", db_seqCont, seg(4'h7));
    press(4'h2);
    chk("w8_hold", db_estado, seg(4'hA));
  endtask

  task automatic test_wrong_press();
    do_reset();
    start(1'b0, 1'b0);
    wait_state(4'h4, (T_ON + T_OFF) + 60);
    press(4'h2);
    wait_state(4'hE, 10);
    chk("wr_flags", 7'({perdeu, pronto, timeout, ganhou}), 7'b1100);
    chk("wr_jogada", db_jogadafeita, seg(4'h2));
    chk("wr_addr", db_contagem, seg(4'h0));
    chk("wr_rom", db_memoria, seg(4'h1));
    chk("wr_igual", 7'(db_igual), 7'd0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    start(1'b0, 1'b1);
    chk("mid_leds", 7'(leds), 7'(rom(1'b1, 0)));
    reset = 1'b1;
    step();
    chk("mid_estado", db_estado, seg(4'h0));
    chk("mid_leds0", 7'(leds), 7'd0);
    chk("mid_mostra", 7'(db_mostra_leds), 7'd0);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    jogar = 1'b0;
    botoes = 4'h0;
    dificuldade = 1'b0;
    memoria = 1'b0;
    test_reset();
    test_rounds_timeout();
    test_wrong_press();
    test_win16();
    test_win8_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
